// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time of a synchronized PWM input in
// clock cycles, counts completed measurements and flags missing edges.
module pwm_capture #(
    parameter int unsigned TIMEOUT = 50_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_pwm,
    output logic [31:0] o_periord,
    output logic [31:0] o_high,
    output logic [15:0] o_times,
    output logic        o_valid,
    output logic        o_timeout,
    output logic        o_busy
);

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned TIMES_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    state_t             state;
    logic               s1;
    logic               s2;
    logic               s2_d;
    logic               rise;
    logic [CNT_W-1:0]   period_cnt;
    logic [CNT_W-1:0]   high_cnt;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= i_pwm;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign rise = s2 & ~s2_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            period_cnt <= '0;
            high_cnt   <= '0;
            o_periord  <= '0;
            o_high     <= '0;
            o_times    <= '0;
            o_valid    <= 1'b0;
            o_timeout  <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_en) begin
                        state      <= ARM;
                        o_times    <= '0;
                        period_cnt <= '0;
                        high_cnt   <= '0;
                        o_busy     <= 1'b1;
                    end else begin
                        o_busy     <= 1'b0;
                    end
                end
                ARM: begin
                    if (!i_en) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else if (rise) begin
                        state      <= MEAS;
                        period_cnt <= CNT_W'(1);
                        high_cnt   <= CNT_W'(1);
                    end
                end
                MEAS: begin
                    if (!i_en) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else if (rise) begin
                        // A rise always wins over a coincident timeout.
                        o_periord  <= period_cnt;
                        o_high     <= high_cnt;
                        o_valid    <= 1'b1;
                        period_cnt <= CNT_W'(1);
                        high_cnt   <= CNT_W'(1);
                        if (o_times != {TIMES_W{1'b1}}) begin
                            o_times <= o_times + TIMES_W'(1);
                        end
                    end else if (period_cnt == CNT_W'(TIMEOUT)) begin
                        state      <= ARM;
                        o_timeout  <= 1'b1;
                        period_cnt <= '0;
                        high_cnt   <= '0;
                    end else begin
                        period_cnt <= period_cnt + CNT_W'(1);
                        if (s2) begin
                            high_cnt <= high_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture: expected measurements come from the
// driven pulse train (period/high per pulse), not from the design's counters.
module tb_pwm_capture;

    localparam int unsigned TO = 5000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        pwm;
    logic [31:0] periord;
    logic [31:0] high;
    logic [15:0] times;
    logic        valid;
    logic        timeout;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] per;
        logic [31:0] hi;
        logic [15:0] tm;
        longint      cyc;
    } meas_t;

    meas_t  vq[$];
    longint to_q[$];
    longint cyc_cnt = 0;
    bit     both_seen = 1'b0;

    pwm_capture #(.TIMEOUT(TO)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_pwm     (pwm),
        .o_periord (periord),
        .o_high    (high),
        .o_times   (times),
        .o_valid   (valid),
        .o_timeout (timeout),
        .o_busy    (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Record every output event away from the active edge.
    always @(negedge clk) begin
        if (valid) vq.push_back('{per: periord, hi: high, tm: times, cyc: cyc_cnt});
        if (timeout) to_q.push_back(cyc_cnt);
        if (valid && timeout) both_seen = 1'b1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int p, input int h);
        pwm = 1'b1;
        cyc(h);
        pwm = 1'b0;
        cyc(p - h);
    endtask

    task automatic check_zero(input string tag);
        total++; if (periord !== 32'd0) begin bad++; $display("FAIL %s periord got %0d want 0", tag, periord); end
        total++; if (high !== 32'd0)    begin bad++; $display("FAIL %s high got %0d want 0", tag, high); end
        total++; if (times !== 16'd0)   begin bad++; $display("FAIL %s times got %0d want 0", tag, times); end
        total++; if (valid !== 1'b0)    begin bad++; $display("FAIL %s valid got %b want 0", tag, valid); end
        total++; if (timeout !== 1'b0)  begin bad++; $display("FAIL %s timeout got %b want 0", tag, timeout); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL %s busy got %b want 0", tag, busy); end
    endtask

    // Compare collected measurements with the list of driven pulses.
    task automatic check_meas(input string tag, input int n, input int ep[$], input int eh[$]);
        total++;
        if (vq.size() != n) begin
            bad++; $display("FAIL %s count got %0d want %0d", tag, vq.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                total++;
                if (vq[i].per !== 32'(ep[i]) || vq[i].hi !== 32'(eh[i]) || vq[i].tm !== 16'(i + 1)) begin
                    bad++;
                    $display("FAIL %s meas%0d got per=%0d hi=%0d tm=%0d want per=%0d hi=%0d tm=%0d",
                             tag, i, vq[i].per, vq[i].hi, vq[i].tm, ep[i], eh[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pwm = ~pwm;
            cyc(1);
        end
        check_zero("reset");
        rst = 1'b0; en = 1'b0; pwm = 1'b0;
        vq.delete();
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) pwm = ~pwm;
            cyc(1);
        end
        pwm = 1'b0;
        total++; if (vq.size() != 0) begin bad++; $display("FAIL reset_release valids got %0d want 0", vq.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_release busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int ep[$];
        int eh[$];
        en = 1'b1; cyc(3);
        vq.delete();
        for (int i = 0; i < 3; i++) pulse(2500, 250);
        cyc(20);
        ep = '{2500, 2500}; eh = '{250, 250};
        check_meas("basic", 2, ep, eh);
        total++; if (times !== 16'd2) begin bad++; $display("FAIL basic times got %0d want 2", times); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic busy got %b want 1", busy); end
    endtask

    task automatic test_reenable();
        int ep[$];
        int eh[$];
        en = 1'b0; cyc(10);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reen_idle busy got %b want 0", busy); end
        total++; if (periord !== 32'd2500) begin bad++; $display("FAIL reen_hold periord got %0d want 2500", periord); end
        en = 1'b1; cyc(2);
        total++; if (times !== 16'd0) begin bad++; $display("FAIL reen_clear times got %0d want 0", times); end
        vq.delete();
        for (int i = 0; i < 5; i++) pulse(1000, 500);
        cyc(10);
        ep = '{1000, 1000, 1000, 1000}; eh = '{500, 500, 500, 500};
        check_meas("reenable", 4, ep, eh);
        total++; if (times !== 16'd4) begin bad++; $display("FAIL reen times got %0d want 4", times); end
        en = 1'b0; cyc(2);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            int ep[$];
            int eh[$];
            int n;
            en = 1'b1; cyc(2);
            vq.delete();
            n = int'($urandom_range(4, 8));
            for (int i = 0; i < n; i++) begin
                int p;
                int h;
                p = int'($urandom_range(4, 400));
                h = int'($urandom_range(2, p - 2));
                ep.push_back(p); eh.push_back(h);
                pulse(p, h);
            end
            cyc(10);
            check_meas("random", n - 1, ep, eh);
            total++; if (times !== 16'(n - 1)) begin bad++; $display("FAIL random times got %0d want %0d", times, n - 1); end
            en = 1'b0; cyc(3);
        end
    endtask

    task automatic test_timeout();
        en = 1'b1; cyc(2);
        vq.delete(); to_q.delete();
        pulse(1000, 500);
        pwm = 1'b1;
        cyc(TO + 50);
        total++;
        if (vq.size() != 1 || vq[0].per !== 32'd1000 || vq[0].hi !== 32'd500) begin
            bad++; $display("FAIL timeout_meas count=%0d want 1 with per=1000 hi=500", vq.size());
        end
        total++;
        if (to_q.size() != 1) begin
            bad++; $display("FAIL timeout_count got %0d want 1", to_q.size());
        end else if (vq.size() >= 1) begin
            total++;
            if (to_q[0] - vq[0].cyc != longint'(TO)) begin
                bad++; $display("FAIL timeout_gap got %0d want %0d", to_q[0] - vq[0].cyc, TO);
            end
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL timeout_busy got %b want 1", busy); end
        total++; if (periord !== 32'd1000) begin bad++; $display("FAIL timeout_hold periord got %0d want 1000", periord); end
        cyc(TO + 1000);
        total++; if (to_q.size() != 1) begin bad++; $display("FAIL arm_no_timeout got %0d want 1", to_q.size()); end
        // Rise landing exactly on the timeout count must measure, not time out.
        pwm = 1'b0; cyc(4);
        pulse(int'(TO), 100);
        pwm = 1'b1; cyc(20);
        total++;
        if (vq.size() != 2 || vq[vq.size()-1].per !== 32'(TO) || vq[vq.size()-1].hi !== 32'd100) begin
            bad++; $display("FAIL edge_at_timeout count=%0d want 2 with per=%0d hi=100", vq.size(), TO);
        end
        total++; if (to_q.size() != 1) begin bad++; $display("FAIL edge_at_timeout timeouts got %0d want 1", to_q.size()); end
        en = 1'b0; pwm = 1'b0; cyc(3);
    endtask

    task automatic test_disable_mid();
        logic [31:0] sp;
        logic [31:0] sh;
        logic [15:0] st;
        en = 1'b1; cyc(2);
        vq.delete();
        pulse(2500, 250);
        pwm = 1'b1; cyc(250);
        pwm = 1'b0; cyc(50);
        sp = periord; sh = high; st = times;
        total++;
        if (vq.size() != 1 || sp !== 32'd2500 || sh !== 32'd250 || st !== 16'd1) begin
            bad++; $display("FAIL dis_pre count=%0d per=%0d hi=%0d tm=%0d want 1 2500 250 1", vq.size(), sp, sh, st);
        end
        en = 1'b0; cyc(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL dis_idle busy got %b want 0", busy); end
        pulse(2500, 250);
        total++; if (vq.size() != 1) begin bad++; $display("FAIL dis_novalid count got %0d want 1", vq.size()); end
        total++;
        if (periord !== sp || high !== sh || times !== st) begin
            bad++; $display("FAIL dis_hold got %0d/%0d/%0d want %0d/%0d/%0d", periord, high, times, sp, sh, st);
        end
    endtask

    task automatic test_reset_mid();
        int ep[$];
        int eh[$];
        en = 1'b1; cyc(2);
        pulse(100, 50);
        pwm = 1'b1; cyc(30);
        rst = 1'b1; cyc(1);
        check_zero("reset_mid");
        rst = 1'b0; pwm = 1'b0; cyc(3);
        vq.delete();
        for (int i = 0; i < 4; i++) begin pulse(10, 2); ep.push_back(10); eh.push_back(2); end
        for (int i = 0; i < 4; i++) begin pulse(10, 8); ep.push_back(10); eh.push_back(8); end
        pwm = 1'b1; cyc(10);
        check_meas("duty", 8, ep, eh);
        total++; if (both_seen) begin bad++; $display("FAIL valid_timeout_overlap got 1 want 0"); end
        en = 1'b0; pwm = 1'b0; cyc(2);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pwm = 1'b0;
        cyc(1);
        test_reset();
        test_basic();
        test_reenable();
        test_random();
        test_timeout();
        test_disable_mid();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
